// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, mnemonic codes, error codes, field positions.
// Combinational helpers only; no state, no latency.
// No handshake; consumed by the encoder and (conceptually) the decoder.
package isa_pkg;

    // Major opcodes, bits [31:27] of every instruction word.
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // Field LSB positions within the 32-bit word.
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    typedef enum logic [4:0] {
        M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_AND = 5'd2,  M_OR   = 5'd3,
        M_SLL  = 5'd4,  M_SRA  = 5'd5,  M_MUL = 5'd6,  M_DIV  = 5'd7,
        M_ADDI = 5'd8,  M_LW   = 5'd9,  M_SW  = 5'd10, M_J    = 5'd11,
        M_JAL  = 5'd12, M_JR   = 5'd13, M_BNE = 5'd14, M_BLT  = 5'd15,
        M_BEX  = 5'd16, M_SETX = 5'd17
    } mnem_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_MNEM   = 2'd1,
        ERR_IMM    = 2'd2,
        ERR_TARGET = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] shamt,
                                           input logic [4:0] aluop);
        return {OP_RTYPE, rd, rs, rt, shamt, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_word(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [31:0] imm);
        return {op, rd, rs, imm[16:0]};
    endfunction

    function automatic logic [31:0] j_word(input logic [4:0] op, input logic [31:0] target);
        return {op, target[26:0]};
    endfunction

endpackage

// File: rtl/insn_encoder_writer_if.sv
// Request bus carrying one symbolic instruction per valid/ready transfer.
// Latency n/a (wires only).
// Transfer happens when req_valid && req_ready at a rising clock edge.
interface insn_encoder_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] target;

    modport master (output req_valid, mnem, rd, rs, rt, shamt, imm, target, input req_ready);
    modport slave  (input  req_valid, mnem, rd, rs, rt, shamt, imm, target, output req_ready);
endinterface

// File: rtl/insn_pack.sv
// Packs mnemonic + fields into a 32-bit word and reports field-check failures.
// Purely combinational (zero latency).
// No handshake; word is meaningful only when code is ERR_NONE.
module insn_pack
    import isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic [31:0] target,
    output logic [31:0] word,
    output logic [1:0]  code
);
    logic imm_ok;
    logic target_ok;

    // imm fits in 17-bit two's complement when bits [31:16] are all equal.
    assign imm_ok    = (imm[31:16] == {16{imm[16]}});
    assign target_ok = (target[31:27] == 5'd0);

    always_comb begin
        word = 32'd0;
        code = ERR_NONE;
        case (mnem)
            M_ADD, M_SUB, M_AND, M_OR, M_MUL, M_DIV:
                word = r_word(rd, rs, rt, 5'd0, mnem);
            M_SLL, M_SRA:
                word = r_word(rd, rs, rt, shamt, mnem);
            M_ADDI, M_LW, M_SW, M_BNE, M_BLT: begin
                case (mnem)
                    M_ADDI:  word = i_word(OP_ADDI, rd, rs, imm);
                    M_LW:    word = i_word(OP_LW,   rd, rs, imm);
                    M_SW:    word = i_word(OP_SW,   rd, rs, imm);
                    M_BNE:   word = i_word(OP_BNE,  rd, rs, imm);
                    default: word = i_word(OP_BLT,  rd, rs, imm);
                endcase
                if (!imm_ok) code = ERR_IMM;
            end
            M_J, M_JAL, M_BEX, M_SETX: begin
                case (mnem)
                    M_J:     word = j_word(OP_J,    target);
                    M_JAL:   word = j_word(OP_JAL,  target);
                    M_BEX:   word = j_word(OP_BEX,  target);
                    default: word = j_word(OP_SETX, target);
                endcase
                if (!target_ok) code = ERR_TARGET;
            end
            M_JR:
                word = {OP_JR, rd, 22'd0};
            default:
                code = ERR_MNEM;
        endcase
    end
endmodule

// File: rtl/insn_encoder_writer.sv
// Encodes accepted instructions and writes them to consecutive imem addresses.
// Latency: accept at edge N -> imem_we/addr/data registered at edge N, held one cycle.
// req_ready high only in RUN (and not during start); imem never stalls.
module insn_encoder_writer
    import isa_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 finish,
    insn_encoder_writer_if.slave req,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [31:0]          imem_data,
    output logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic                 full,
    output logic                 err,
    output logic [1:0]           err_code
);
    state_e            state;
    logic [ADDR_W-1:0] addr_ctr;
    logic [31:0]       pack_word;
    logic [1:0]        pack_code;
    logic              accept;

    insn_pack u_pack (
        .mnem   (req.mnem),
        .rd     (req.rd),
        .rs     (req.rs),
        .rt     (req.rt),
        .shamt  (req.shamt),
        .imm    (req.imm),
        .target (req.target),
        .word   (pack_word),
        .code   (pack_code)
    );

    // A start pulse restarts the run, so nothing is taken in that cycle.
    assign req.req_ready = (state == S_RUN) && !start;
    assign accept        = req.req_valid && req.req_ready;

    assign busy = (state == S_RUN);
    assign full = (state == S_FULL);
    assign err  = (state == S_ERR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_ctr  <= '0;
            count     <= '0;
            err_code  <= ERR_NONE;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state    <= S_RUN;
                addr_ctr <= base_addr;
                count    <= '0;
                err_code <= ERR_NONE;
            end else begin
                if (accept) begin
                    if (pack_code != ERR_NONE) begin
                        state    <= S_ERR;
                        err_code <= pack_code;
                    end else begin
                        imem_we   <= 1'b1;
                        imem_addr <= addr_ctr;
                        imem_data <= pack_word;
                        count     <= count + 1'b1;
                        // Last address written: stop rather than wrap.
                        if (&addr_ctr) state <= S_FULL;
                        else           addr_ctr <= addr_ctr + 1'b1;
                    end
                end
                // finish overrides the next state but lets a same-cycle write land.
                if (finish) state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_insn_encoder_writer.sv
module tb_insn_encoder_writer;
    import isa_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = 12'd0;
    logic        finish = 1'b0;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [12:0] count;
    logic        busy, full, err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    insn_encoder_writer_if bus();

    insn_encoder_writer #(.ADDR_W(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .finish    (finish),
        .req       (bus),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .count     (count),
        .busy      (busy),
        .full      (full),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  m, rd, rs, rt, sh;
        logic [31:0] imm, tg;
        logic [31:0] exp_dat;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic [4:0] m, rd, rs, rt, sh,
                                input logic [31:0] imm, tg, exp_dat, input logic [1:0] exp_err);
        vec_t v;
        v.m = m; v.rd = rd; v.rs = rs; v.rt = rt; v.sh = sh;
        v.imm = imm; v.tg = tg; v.exp_dat = exp_dat; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] m, rd, rs, rt, sh, input logic [31:0] imm, tg);
        bus.mnem = m; bus.rd = rd; bus.rs = rs; bus.rt = rt; bus.shamt = sh;
        bus.imm = imm; bus.target = tg;
    endtask

    task automatic do_start(input logic [11:0] b);
        @(negedge clock);
        start = 1'b1;
        base_addr = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"},  {20'd0, imem_addr}, 32'd0);
        chk({tag, "_data"},  imem_data, 32'd0);
        chk({tag, "_count"}, {19'd0, count}, 32'd0);
        chk({tag, "_flags"}, {28'd0, busy, full, err, 1'b0}, 32'd0);
        chk({tag, "_code"},  {30'd0, err_code}, 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);

        // Table: mnem rd rs rt shamt imm target -> word, err_code
        vecs[0]  = mk(5'd8,  5'd3, 5'd0, 5'd0, 5'd0,  32'd5,          32'd0,         32'h28C00005, 2'd0);
        vecs[1]  = mk(5'd0,  5'd1, 5'd2, 5'd3, 5'd0,  32'd0,          32'd0,         32'h00443000, 2'd0);
        vecs[2]  = mk(5'd4,  5'd4, 5'd4, 5'd0, 5'd2,  32'd0,          32'd0,         32'h01080110, 2'd0);
        vecs[3]  = mk(5'd1,  5'd1, 5'd2, 5'd3, 5'd7,  32'd0,          32'd0,         32'h00443004, 2'd0);
        vecs[4]  = mk(5'd5,  5'd5, 5'd6, 5'd7, 5'd31, 32'd0,          32'd0,         32'h014C7F94, 2'd0);
        vecs[5]  = mk(5'd11, 5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'h07FFFFFF,  32'h0FFFFFFF, 2'd0);
        vecs[6]  = mk(5'd17, 5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'h08000000,  32'h0,        2'd3);
        vecs[7]  = mk(5'd8,  5'd0, 5'd0, 5'd0, 5'd0,  32'hFFFFFFFF,   32'd0,         32'h2801FFFF, 2'd0);
        vecs[8]  = mk(5'd9,  5'd0, 5'd0, 5'd0, 5'd0,  32'd65536,      32'd0,         32'h0,        2'd2);
        vecs[9]  = mk(5'd9,  5'd2, 5'd1, 5'd0, 5'd0,  32'd65535,      32'd0,         32'h4082FFFF, 2'd0);
        vecs[10] = mk(5'd10, 5'd0, 5'd0, 5'd0, 5'd0,  32'hFFFF0000,   32'd0,         32'h38010000, 2'd0);
        vecs[11] = mk(5'd14, 5'd0, 5'd0, 5'd0, 5'd0,  32'hFFFEFFFF,   32'd0,         32'h0,        2'd2);
        vecs[12] = mk(5'd15, 5'd1, 5'd2, 5'd0, 5'd0,  32'h10,         32'd0,         32'h30440010, 2'd0);
        vecs[13] = mk(5'd12, 5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'h123,       32'h18000123, 2'd0);
        vecs[14] = mk(5'd16, 5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'd0,         32'hB0000000, 2'd0);
        vecs[15] = mk(5'd13, 5'd31, 5'd3, 5'd3, 5'd3, 32'd0,          32'd0,         32'h27C00000, 2'd0);
        vecs[16] = mk(5'd18, 5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'd0,         32'h0,        2'd1);
        vecs[17] = mk(5'd31, 5'd0, 5'd0, 5'd0, 5'd0,  32'h80000000,   32'hFFFFFFFF,  32'h0,        2'd1);
        vecs[18] = mk(5'd7,  5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'd0,         32'h0000001C, 2'd0);
        vecs[19] = mk(5'd6,  5'd1, 5'd0, 5'd0, 5'd0,  32'h80000000,   32'hFFFFFFFF,  32'h00400018, 2'd0);
        vecs[20] = mk(5'd8,  5'd0, 5'd0, 5'd0, 5'd0,  32'd0,          32'hFFFFFFFF,  32'h28000000, 2'd0);
        vecs[21] = mk(5'd11, 5'd0, 5'd0, 5'd0, 5'd0,  32'h80000000,   32'h08000000,  32'h0,        2'd3);

        // Reset state, during and after reset.
        #12;
        check_reset_vals("in_reset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals("post_reset");

        // Table-driven: each vector on a fresh run at 0x100.
        for (int i = 0; i < 22; i++) begin
            do_start(12'h100);
            @(negedge clock);
            set_req(vecs[i].m, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].sh, vecs[i].imm, vecs[i].tg);
            bus.req_valid = 1'b1;
            @(posedge clock); #1;
            bus.req_valid = 1'b0;
            chk($sformatf("v%0d_we", i), {31'd0, imem_we}, {31'd0, vecs[i].exp_err == 2'd0});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err != 2'd0});
            chk($sformatf("v%0d_code", i), {30'd0, err_code}, {30'd0, vecs[i].exp_err});
            if (vecs[i].exp_err == 2'd0) begin
                chk($sformatf("v%0d_data", i), imem_data, vecs[i].exp_dat);
                chk($sformatf("v%0d_addr", i), {20'd0, imem_addr}, 32'h100);
                chk($sformatf("v%0d_count", i), {19'd0, count}, 32'd1);
            end else begin
                chk($sformatf("v%0d_ready", i), {31'd0, bus.req_ready}, 32'd0);
                chk($sformatf("v%0d_count", i), {19'd0, count}, 32'd0);
            end
        end

        // Error clears on a new start.
        do_start(12'h010);
        chk("restart_err", {31'd0, err}, 32'd0);
        chk("restart_code", {30'd0, err_code}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);

        // Back-to-back: ADD then SLL on consecutive cycles.
        @(negedge clock);
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 32'd0);
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        chk("b2b0_we", {31'd0, imem_we}, 32'd1);
        chk("b2b0_addr", {20'd0, imem_addr}, 32'h010);
        chk("b2b0_data", imem_data, 32'h00443000);
        set_req(5'd4, 5'd4, 5'd4, 5'd0, 5'd4, 32'd0, 32'd0);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("b2b1_we", {31'd0, imem_we}, 32'd1);
        chk("b2b1_addr", {20'd0, imem_addr}, 32'h011);
        chk("b2b1_data", imem_data, 32'h01080210);
        chk("b2b1_count", {19'd0, count}, 32'd2);
        @(posedge clock); #1;
        chk("b2b_idle_we", {31'd0, imem_we}, 32'd0);
        chk("b2b_hold_addr", {20'd0, imem_addr}, 32'h011);

        // Top of memory: three requests, two writes, then FULL.
        do_start(12'hFFE);
        @(negedge clock);
        set_req(5'd8, 5'd1, 5'd0, 5'd0, 5'd0, 32'd1, 32'd0);
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        chk("full0_addr", {20'd0, imem_addr}, 32'hFFE);
        chk("full0_full", {31'd0, full}, 32'd0);
        @(posedge clock); #1;
        chk("full1_we", {31'd0, imem_we}, 32'd1);
        chk("full1_addr", {20'd0, imem_addr}, 32'hFFF);
        chk("full1_full", {31'd0, full}, 32'd1);
        chk("full1_count", {19'd0, count}, 32'd2);
        chk("full1_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("full2_we", {31'd0, imem_we}, 32'd0);
        chk("full2_count", {19'd0, count}, 32'd2);
        chk("full2_busy", {31'd0, busy}, 32'd0);

        // finish with a same-cycle request: the write still lands.
        do_start(12'h020);
        @(negedge clock);
        set_req(5'd8, 5'd2, 5'd0, 5'd0, 5'd0, 32'd7, 32'd0);
        bus.req_valid = 1'b1;
        finish = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        finish = 1'b0;
        chk("fin_we", {31'd0, imem_we}, 32'd1);
        chk("fin_addr", {20'd0, imem_addr}, 32'h020);
        chk("fin_data", imem_data, 32'h28800007);
        chk("fin_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        chk("fin_count_held", {19'd0, count}, 32'd1);
        chk("fin_ready", {31'd0, bus.req_ready}, 32'd0);

        // start with a same-cycle request: not accepted that cycle.
        do_start(12'h040);
        @(negedge clock);
        start = 1'b1;
        base_addr = 12'h030;
        set_req(5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 32'd9, 32'd0);
        bus.req_valid = 1'b1;
        #1;
        chk("startreq_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
        chk("startreq_we", {31'd0, imem_we}, 32'd0);
        chk("startreq_count", {19'd0, count}, 32'd0);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("startreq_next_addr", {20'd0, imem_addr}, 32'h030);
        chk("startreq_next_data", imem_data, 32'h28000009);

        // Async reset during a write cycle.
        do_start(12'h050);
        @(negedge clock);
        set_req(5'd8, 5'd3, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0);
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        chk("arst_pre_we", {31'd0, imem_we}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("arst_idle_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
